// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between the core datapath (0) and the auxiliary unit (1).
// Optional multi-cycle MUL EXEC phase is compiled in with `define ALU_ARB_MULTICYCLE_MUL_EN.
module alu_share_arbiter #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_SrcA,
    input  logic [WIDTH-1:0] req0_SrcB,
    input  logic [2:0]       req0_S,
    input  logic [WIDTH-1:0] req1_SrcA,
    input  logic [WIDTH-1:0] req1_SrcB,
    input  logic [2:0]       req1_S,
    output logic [WIDTH-1:0] alu_SrcA,
    output logic [WIDTH-1:0] alu_SrcB,
    output logic [2:0]       alu_S,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic             zeroflag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t state, state_next;
    logic   last_grant;
    logic   winner;
    logic   grant;
    logic   exec_done;

    if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
        $error("MUL_CYCLES must be in 1..15");
    end

    // Under contention the requester that did not win last time goes first.
    always_comb begin
        winner = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
        grant  = (state == IDLE) && (req_valid != 2'b00) && !reset;
    end

`ifdef ALU_ARB_MULTICYCLE_MUL_EN
    logic [3:0] exec_cnt;
    logic [2:0] win_s;

    assign win_s     = winner ? req1_S : req0_S;
    assign exec_done = (exec_cnt <= 4'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            exec_cnt <= 4'd0;
        end else if (grant) begin
            exec_cnt <= (win_s == 3'b101) ? 4'(MUL_CYCLES) : 4'd1;
        end else if (state == EXEC && !exec_done) begin
            exec_cnt <= exec_cnt - 4'd1;
        end
    end
`else
    assign exec_done = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: each combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant)     state_next = EXEC;
            EXEC:    if (exec_done) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        if (grant) req_ready = winner ? 2'b10 : 2'b01;
        busy = (state != IDLE);
    end

    // alu_* deliberately keep the last operands after a transaction to avoid toggling the ALU.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_SrcA   <= '0;
            alu_SrcB   <= '0;
            alu_S      <= 3'b000;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        alu_SrcA   <= winner ? req1_SrcA : req0_SrcA;
                        alu_SrcB   <= winner ? req1_SrcB : req0_SrcB;
                        alu_S      <= winner ? req1_S    : req0_S;
                        last_grant <= winner;
                        rsp_id     <= winner;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        rsp_result <= ALUResult;
                        rsp_zero   <= zeroflag;
                        rsp_valid  <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached to the alu_* port.
// MUL latency expectation follows ALU_ARB_MULTICYCLE_MUL_EN.
module tb_alu_share_arbiter;

    localparam int WIDTH = 32;
`ifdef ALU_ARB_MULTICYCLE_MUL_EN
    localparam int MUL_LAT = 5;
`else
    localparam int MUL_LAT = 2;
`endif

    logic             clk;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req0_SrcA, req0_SrcB, req1_SrcA, req1_SrcB;
    logic [2:0]       req0_S, req1_S;
    logic [WIDTH-1:0] alu_SrcA, alu_SrcB;
    logic [2:0]       alu_S;
    logic [WIDTH-1:0] ALUResult;
    logic             zeroflag;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
    logic [WIDTH-1:0] rsp_result;

    int checks   = 0;
    int failures = 0;

    alu_share_arbiter #(.WIDTH(WIDTH), .MUL_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_SrcA(req0_SrcA), .req0_SrcB(req0_SrcB), .req0_S(req0_S),
        .req1_SrcA(req1_SrcA), .req1_SrcB(req1_SrcB), .req1_S(req1_S),
        .alu_SrcA(alu_SrcA), .alu_SrcB(alu_SrcB), .alu_S(alu_S),
        .ALUResult(ALUResult), .zeroflag(zeroflag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (alu_S)
            3'b000:  ALUResult = alu_SrcA & alu_SrcB;
            3'b001:  ALUResult = alu_SrcA | alu_SrcB;
            3'b010:  ALUResult = alu_SrcA + alu_SrcB;
            3'b100:  ALUResult = alu_SrcA - alu_SrcB;
            3'b101:  ALUResult = alu_SrcA * alu_SrcB;
            3'b110:  ALUResult = WIDTH'(alu_SrcA < alu_SrcB);
            default: ALUResult = '0;
        endcase
        zeroflag = (ALUResult == '0);
    end

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Returns 2 time units after a rising edge; inputs are driven here and outputs sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic single_txn(input string tag, input logic id, input logic [2:0] s,
                              input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [WIDTH-1:0] exp_res, input logic exp_zero,
                              input int exp_lat);
        int n;
        if (id) begin req1_S = s; req1_SrcA = a; req1_SrcB = b; req_valid = 2'b10; end
        else    begin req0_S = s; req0_SrcA = a; req0_SrcB = b; req_valid = 2'b01; end
        rsp_ready = 1'b1;
        #1;
        n = 0;
        while (req_ready == 2'b00 && n < 20) begin step(); #1; n++; end
        check({tag, "_grant"}, 64'(req_ready), id ? 64'h2 : 64'h1);
        step();
        req_valid = 2'b00;
        #1;
        check({tag, "_exec_busy_noready"}, {busy, req_ready}, 64'h4);
        n = 1;
        while (!rsp_valid && n < 40) begin step(); #1; n++; end
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_rsp_id"}, 64'(rsp_id), 64'(id));
        check({tag, "_rsp_result"}, 64'(rsp_result), 64'(exp_res));
        check({tag, "_rsp_zero"}, 64'(rsp_zero), 64'(exp_zero));
        step();
        #1;
        check({tag, "_back_idle"}, {rsp_valid, busy}, 64'h0);
    endtask

    initial begin : main
        logic [1:0] grant_order [3];
        int         seen;
        grant_order = '{2'b01, 2'b10, 2'b01};
        req0_SrcA = '0; req0_SrcB = '0; req0_S = 3'b000;
        req1_SrcA = '0; req1_SrcB = '0; req1_S = 3'b000;

        // Reset state
        do_reset();
        check("reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_zero, busy, alu_S},
              64'h0);
        check("reset_rsp_result", 64'(rsp_result), 64'h0);
        check("reset_alu_ops", {alu_SrcA, alu_SrcB}, 64'h0);

        // Single ADD from requester 0
        single_txn("add", 1'b0, 3'b010, 32'd5, 32'd3, 32'd8, 1'b0, 2);

        // Continuous contention alternates 0,1,0
        do_reset();
        req0_S = 3'b100; req0_SrcA = 32'd7;    req0_SrcB = 32'd7;
        req1_S = 3'b001; req1_SrcA = 32'hF0;   req1_SrcB = 32'h0F;
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("cont_grant%0d", k), 64'(req_ready), 64'(grant_order[k]));
            step();
            step();
            #1;
            check($sformatf("cont_rsp%0d", k),
                  {rsp_valid, rsp_id, rsp_zero, rsp_result},
                  grant_order[k][1] ? {3'b110, 32'hFF} : {3'b101, 32'h0});
            step();
            #1;
        end
        req_valid = 2'b00;
        step();
        step();
        step();

        // Backpressure with requester 1 waiting
        do_reset();
        req0_S = 3'b010; req0_SrcA = 32'd1;  req0_SrcB = 32'd2;
        req1_S = 3'b000; req1_SrcA = 32'hC;  req1_SrcB = 32'hA;
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        #1;
        check("bp_grant0", 64'(req_ready), 64'h1);
        step();
        req_valid = 2'b10;
        step();
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp_hold%0d", k), {req_ready, rsp_valid, rsp_id, rsp_zero, rsp_result},
                  {5'b00100, 32'd3});
            if (k == 4) rsp_ready = 1'b1;
            step();
        end
        #1;
        check("bp_grant1", {req_ready, rsp_valid}, 64'h4);
        step();
        req_valid = 2'b00;
        step();
        #1;
        check("bp_rsp1", {rsp_valid, rsp_id, rsp_zero, rsp_result}, {3'b110, 32'h8});
        step();

        // SLT and undefined opcode
        single_txn("slt", 1'b1, 3'b110, 32'd2, 32'd9, 32'd1, 1'b0, 2);
        single_txn("undef", 1'b0, 3'b111, 32'd12, 32'd34, 32'd0, 1'b1, 2);

        // Reset during EXEC aborts the transaction
        do_reset();
        req0_S = 3'b010; req0_SrcA = 32'd1; req0_SrcB = 32'd1;
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        #1;
        check("abort_in_exec", 64'(busy), 64'h1);
        reset = 1'b1;
        step();
        #1;
        check("abort_outputs", {rsp_valid, busy, alu_S}, 64'h0);
        check("abort_alu_ops", {alu_SrcA, alu_SrcB}, 64'h0);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            #1;
            if (rsp_valid || busy) seen++;
        end
        check("abort_no_response", 64'(seen), 64'h0);

        // MUL: latency depends on the multi-cycle build option
        do_reset();
        single_txn("mul", 1'b0, 3'b101, 32'd6, 32'd7, 32'd42, 1'b0, MUL_LAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
